// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding,
// default widths and the NOP instruction word.
package fetch_ctrl_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready output register for fetched words. A flush drops the held word
// and wins over both a new load and an accept in the same cycle.
module fetch_out_reg #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic              ready_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              free_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      pc_d    = pc_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives the combinational-read
// instruction memory and hands words to decode over valid/ready.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int                 ADDR_W   = ADDR_W_DEF,
  parameter int                 DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              running,
  output logic [15:0]       fetch_cnt
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              free, fetch, accept;

  assign running   = (state_q == ST_RUN);
  assign imem_addr = pc_q;
  assign fetch_cnt = cnt_q;
  assign fetch     = running && free && !redir_valid && !halt;
  // A redirect flushes the held word, so it never counts as accepted.
  assign accept    = inst_valid && inst_ready && !redir_valid;

  fetch_out_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_out (
    .clk     (clk),
    .rst     (rst),
    .load_i  (fetch),
    .flush_i (redir_valid),
    .ready_i (inst_ready),
    .data_i  (imem_data),
    .pc_i    (pc_q),
    .valid_o (inst_valid),
    .data_o  (inst),
    .pc_o    (inst_pc),
    .free_o  (free)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_RUN;
      ST_RUN:    if (halt)  state_d = ST_HALTED;
      ST_HALTED: if (start) state_d = ST_RUN;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (redir_valid)  pc_d = redir_pc;
    else if (fetch)   pc_d = pc_q + ADDR_W'(1);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized + directed bench for fetch_ctrl with a transaction-level model
// and a scoreboard of expected accepted words.
module tb_fetch_ctrl;

  localparam int AW = 10;
  localparam int DW = 32;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] w;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, halt = 1'b0, redir_valid = 1'b0, inst_ready = 1'b0;
  logic [AW-1:0] redir_pc = '0;
  logic [AW-1:0] imem_addr, inst_pc;
  logic [DW-1:0] imem_data, inst;
  logic          inst_valid, running;
  logic [15:0]   fetch_cnt;

  logic [DW-1:0] im [1024];
  assign imem_data = im[imem_addr];

  always #5 clk = ~clk;

  fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc),
    .running(running), .fetch_cnt(fetch_cnt)
  );

  // Model state as visible between clock edges.
  bit            m_run = 0;
  bit            m_vld = 0;
  logic [AW-1:0] m_pc  = '0;
  logic [AW-1:0] m_vpc = '0;
  int            m_cnt = 0;
  exp_t          q[$];
  exp_t          mon_e;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, predict the outcome, advance past the edge.
  task automatic cyc(input bit s, input bit h, input bit r, input logic [AW-1:0] rpc, input bit rdy);
    bit            hs, fetch, n_run, n_vld;
    logic [AW-1:0] n_pc, n_vpc;
    int            n_cnt;
    start = s; halt = h; redir_valid = r; redir_pc = rpc; inst_ready = rdy;
    hs    = m_vld && rdy && !r;
    fetch = m_run && (!m_vld || rdy) && !r && !h;
    n_pc = m_pc; n_vld = m_vld; n_vpc = m_vpc; n_run = m_run; n_cnt = m_cnt;
    if (hs) begin
      q.push_back('{m_vpc, im[m_vpc]});
      if (m_cnt < 65535) n_cnt = m_cnt + 1;
    end
    if (r) begin
      n_pc = rpc; n_vld = 0;
    end else if (fetch) begin
      n_vld = 1; n_vpc = m_pc; n_pc = AW'((int'(m_pc) + 1) % 1024);
    end else if (hs) begin
      n_vld = 0;
    end
    if (m_run && h) n_run = 0;
    else if (!m_run && s) n_run = 1;
    @(posedge clk);
    m_pc = n_pc; m_vld = n_vld; m_vpc = n_vpc; m_run = n_run; m_cnt = n_cnt;
    #1;
  endtask

  task automatic idle_rdy(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, 1);
  endtask

  always @(negedge clk) begin
    chk("inst_valid", 64'(inst_valid), 64'(m_vld));
    chk("running", 64'(running), 64'(m_run));
    chk("imem_addr", 64'(imem_addr), 64'(m_pc));
    chk("fetch_cnt", 64'(fetch_cnt), 64'(m_cnt));
    if (m_vld) chk("inst_pc_held", 64'(inst_pc), 64'(m_vpc));
    if (inst_valid && inst_ready && !redir_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL accept_unexpected: got inst_pc %0h expected no handshake at %0t", inst_pc, $time);
      end else begin
        mon_e = q.pop_front();
        chk("accept_pc", 64'(inst_pc), 64'(mon_e.pc));
        chk("accept_inst", 64'(inst), 64'(mon_e.w));
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) im[i] = $urandom;
    im[0] = 32'h20100001; im[1] = 32'h012A4820;
    im[2] = 32'h20100006; im[3] = 32'h012A4822;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_inst", 64'(inst), 64'h0);
    chk("rst_inst_pc", 64'(inst_pc), 64'h0);
    rst = 1'b0;
    cyc(0, 0, 0, '0, 1);
    cyc(0, 0, 0, '0, 1);

    // Sequential start-up, then 3 cycles of back-pressure on inst_pc=1.
    cyc(1, 0, 0, '0, 1);
    idle_rdy(2);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, '0, 0);
    idle_rdy(3);

    // Redirect flush with ready high, then wrap at the top of memory.
    cyc(0, 0, 1, AW'(42), 1);
    idle_rdy(3);
    cyc(0, 0, 1, AW'(1023), 1);
    idle_rdy(3);

    // Halt under back-pressure, drain, restart.
    cyc(0, 1, 0, '0, 0);
    cyc(0, 0, 0, '0, 0);
    cyc(0, 0, 0, '0, 0);
    idle_rdy(3);
    cyc(1, 0, 0, '0, 1);
    idle_rdy(3);

    // Start and halt together while running: halt wins.
    cyc(1, 1, 0, '0, 1);
    idle_rdy(2);
    cyc(0, 0, 1, AW'(7), 0);
    cyc(1, 0, 0, '0, 1);
    idle_rdy(2);

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 19) == 0, AW'($urandom_range(0, 1023)),
          $urandom_range(0, 9) < 7);
    end

    // Asynchronous reset mid-run with a valid word held.
    cyc(1, 0, 0, '0, 1);
    idle_rdy(2);
    cyc(0, 0, 0, '0, 0);
    rst = 1'b1;
    start = 0; halt = 0; redir_valid = 0; inst_ready = 0;
    m_run = 0; m_vld = 0; m_pc = '0; m_vpc = '0; m_cnt = 0;
    q.delete();
    #1;
    chk("amid_inst_valid", 64'(inst_valid), 64'h0);
    chk("amid_running", 64'(running), 64'h0);
    chk("amid_imem_addr", 64'(imem_addr), 64'h0);
    chk("amid_fetch_cnt", 64'(fetch_cnt), 64'h0);
    chk("amid_inst", 64'(inst), 64'h0);
    chk("amid_inst_pc", 64'(inst_pc), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_rdy(3);
    cyc(1, 0, 0, '0, 1);
    idle_rdy(4);

    chk("queue_empty", 64'(q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
